// File: rtl/sieve_pkg.sv
// Shared definitions for the prime-sieve scanner: FSM encoding, first
// candidate and the composite-bit convention agreed with the marker.
package sieve_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    READ = 3'd1,
    WAIT = 3'd2,
    EMIT = 3'd3,
    DONE = 3'd4
  } scan_state_t;

  // Smallest prime; the scan always starts here.
  localparam int   FIRST_PRIME    = 2;
  // Bitmap value the marker writes for a composite address.
  localparam logic MARK_COMPOSITE = 1'b1;

endpackage

// File: rtl/sieve_scan_outbuf.sv
// Single-entry valid/ready holding register for the prime output stream.
// Valid is purely registered; Ready only affects the next-cycle state.
module sieve_scan_outbuf #(
  parameter int width = 32
) (
  input  logic             Clock,
  input  logic             Reset_n,
  input  logic             Load,
  input  logic [width-1:0] Load_Data,
  input  logic             Ready,
  output logic [width-1:0] Prime,
  output logic             Prime_Valid,
  output logic             Take
);

  // A transfer happens on any cycle the held entry meets Ready.
  assign Take = Prime_Valid & Ready;

  // Capture a new prime, hold it until taken, then drop Valid.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      Prime       <= '0;
      Prime_Valid <= 1'b0;
    end else if (Load) begin
      Prime       <= Load_Data;
      Prime_Valid <= 1'b1;
    end else if (Take) begin
      Prime_Valid <= 1'b0;
    end
  end

endmodule

// File: rtl/sieve_scanner.sv
// Sieve bitmap reader: walks addresses 2..count_limit-1 after marking,
// emits every unmarked address as a prime and counts transfers.
// Optional build macro SIEVE_SCAN_SKIP_EVEN_EN: emit 2 without a read and
// then only read odd addresses.
module sieve_scanner
  import sieve_pkg::*;
#(
  parameter int width       = 32,
  parameter int count_limit = 1000000
) (
  input  logic             Clock,
  input  logic             Reset_n,
  input  logic             Start,
  output logic [width-1:0] Mem_Addr,
  output logic             Mem_RdEn,
  input  logic             Mem_RdData,
  output logic [width-1:0] Prime,
  output logic             Prime_Valid,
  input  logic             Prime_Ready,
  output logic [width-1:0] Prime_Count,
  output logic             Busy,
  output logic             Done
);

  // Nothing to scan when the range 2..count_limit-1 is empty.
  localparam bit NO_CANDIDATES = (count_limit <= FIRST_PRIME);
  // Last candidate, held one bit wider so candidate+step never wraps.
  localparam logic [width:0] LAST =
    NO_CANDIDATES ? '0 : (width+1)'(count_limit - 1);

  scan_state_t      state;
  logic [width-1:0] cand;
  logic [width:0]   step;
  logic [width:0]   cand_next;
  logic             past_end;
  logic             start_ok;
  logic             ob_load;
  logic [width-1:0] ob_data;
  logic             xfer;

  assign start_ok = Start && (state == IDLE || state == DONE);

  // Next candidate and end-of-range test, done in width+1 bits.
  always_comb begin
    step = (width+1)'(1);
`ifdef SIEVE_SCAN_SKIP_EVEN_EN
    // After 2 only odd numbers can be prime.
    if (cand != width'(FIRST_PRIME)) step = (width+1)'(2);
`endif
    cand_next = {1'b0, cand} + step;
    past_end  = (cand_next > LAST);
  end

  // Output buffer is loaded on an unmarked read, or with 2 directly when
  // even addresses are skipped.
  always_comb begin
    ob_load = (state == WAIT) && (Mem_RdData != MARK_COMPOSITE);
`ifdef SIEVE_SCAN_SKIP_EVEN_EN
    if (start_ok && !NO_CANDIDATES) ob_load = 1'b1;
`endif
    ob_data = (state == WAIT) ? cand : width'(FIRST_PRIME);
  end

  sieve_scan_outbuf #(.width(width)) u_outbuf (
    .Clock       (Clock),
    .Reset_n     (Reset_n),
    .Load        (ob_load),
    .Load_Data   (ob_data),
    .Ready       (Prime_Ready),
    .Prime       (Prime),
    .Prime_Valid (Prime_Valid),
    .Take        (xfer)
  );

  // Scan FSM with registered RAM strobe, status flags and prime counter.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state       <= IDLE;
      cand        <= width'(FIRST_PRIME);
      Mem_Addr    <= '0;
      Mem_RdEn    <= 1'b0;
      Prime_Count <= '0;
      Busy        <= 1'b0;
      Done        <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (Start) begin
            Prime_Count <= '0;
            cand        <= width'(FIRST_PRIME);
            if (NO_CANDIDATES) begin
              state <= DONE;
              Done  <= 1'b1;
              Busy  <= 1'b0;
            end else begin
              Done <= 1'b0;
              Busy <= 1'b1;
`ifdef SIEVE_SCAN_SKIP_EVEN_EN
              state <= EMIT;
`else
              state    <= READ;
              Mem_Addr <= width'(FIRST_PRIME);
              Mem_RdEn <= 1'b1;
`endif
            end
          end
        end
        READ: begin
          Mem_RdEn <= 1'b0;
          state    <= WAIT;
        end
        WAIT: begin
          if (Mem_RdData != MARK_COMPOSITE) begin
            state <= EMIT;
          end else if (past_end) begin
            state <= DONE;
            Busy  <= 1'b0;
            Done  <= 1'b1;
          end else begin
            state    <= READ;
            cand     <= cand_next[width-1:0];
            Mem_Addr <= cand_next[width-1:0];
            Mem_RdEn <= 1'b1;
          end
        end
        EMIT: begin
          if (xfer) begin
            if (Prime_Count != '1) Prime_Count <= Prime_Count + 1'b1;
            if (past_end) begin
              state <= DONE;
              Busy  <= 1'b0;
              Done  <= 1'b1;
            end else begin
              state    <= READ;
              cand     <= cand_next[width-1:0];
              Mem_Addr <= cand_next[width-1:0];
              Mem_RdEn <= 1'b1;
            end
          end
        end
        default: begin
          state    <= IDLE;
          Mem_RdEn <= 1'b0;
          Busy     <= 1'b0;
          Done     <= 1'b0;
        end
      endcase
    end
  end

endmodule
